// File: rtl/alu_issue_stage.sv
// Issue-stage register in front of the 32-bit ALU: decodes ALU control, selects and
// forwards operands, and keeps held operands fresh while the ALU stage stalls.
module alu_issue_stage #(
    parameter int unsigned RA_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_rs_data,
    input  logic [31:0]     i_rt_data,
    input  logic [RA_W-1:0] i_rs_addr,
    input  logic [RA_W-1:0] i_rt_addr,
    input  logic [RA_W-1:0] i_rd_addr,
    input  logic [15:0]     i_imm,
    input  logic            i_alu_src,
    input  logic [1:0]      i_alu_op,
    input  logic [5:0]      i_funct,
    input  logic            i_reg_write,
    input  logic            i_flush,
    input  logic            i_exmem_we,
    input  logic [RA_W-1:0] i_exmem_rd,
    input  logic [31:0]     i_exmem_data,
    input  logic            i_memwb_we,
    input  logic [RA_W-1:0] i_memwb_rd,
    input  logic [31:0]     i_memwb_data,
    input  logic            i_ex_ready,
    output logic            o_valid,
    output logic [31:0]     o_op1,
    output logic [31:0]     o_op2,
    output logic [3:0]      o_control,
    output logic [RA_W-1:0] o_rd_addr,
    output logic            o_reg_write,
    output logic            o_illegal
);

    localparam int unsigned WIDTH = 32;

    logic [RA_W-1:0]  rs_addr_q;
    logic [RA_W-1:0]  rt_addr_q;
    logic             alu_src_q;

    logic [3:0]       ctrl_d;
    logic             illegal_d;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] rs_fwd;
    logic [WIDTH-1:0] rt_fwd;
    logic [WIDTH-1:0] op1_refresh;
    logic [WIDTH-1:0] op2_refresh;
    logic             load;

    // EX/MEM wins over MEM/WB; register 0 is never forwarded.
    function automatic logic [WIDTH-1:0] fwd(input logic [RA_W-1:0] addr,
                                             input logic [WIDTH-1:0] dflt);
        logic [WIDTH-1:0] r;
        r = dflt;
        if (addr != '0) begin
            if (i_exmem_we && (i_exmem_rd == addr))
                r = i_exmem_data;
            else if (i_memwb_we && (i_memwb_rd == addr))
                r = i_memwb_data;
        end
        return r;
    endfunction

    always_comb begin
        ctrl_d    = 4'b0010;
        illegal_d = 1'b0;
        case (i_alu_op)
            2'b00: ctrl_d = 4'b0010;
            2'b01: ctrl_d = 4'b0110;
            2'b11: ctrl_d = 4'b0001;
            default: begin
                case (i_funct)
                    6'b100000, 6'b100001: ctrl_d = 4'b0010;
                    6'b100010, 6'b100011: ctrl_d = 4'b0110;
                    6'b100100:            ctrl_d = 4'b0000;
                    6'b100101:            ctrl_d = 4'b0001;
                    6'b100111:            ctrl_d = 4'b1100;
                    6'b101010:            ctrl_d = 4'b0111;
                    default: begin
                        ctrl_d    = 4'b0010;
                        illegal_d = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        imm_ext     = (i_alu_op == 2'b11) ? {16'h0000, i_imm} : {{16{i_imm[15]}}, i_imm};
        rs_fwd      = fwd(i_rs_addr, i_rs_data);
        rt_fwd      = fwd(i_rt_addr, i_rt_data);
        // Held operands are refreshed from the stored source addresses; immediates are left alone.
        op1_refresh = fwd(rs_addr_q, o_op1);
        op2_refresh = alu_src_q ? o_op2 : fwd(rt_addr_q, o_op2);
    end

    assign o_ready = ~o_valid | i_ex_ready;
    assign load    = i_valid & o_ready & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_op1       <= '0;
            o_op2       <= '0;
            o_control   <= 4'b0010;
            o_rd_addr   <= '0;
            o_reg_write <= 1'b0;
            o_illegal   <= 1'b0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            alu_src_q   <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (load) begin
            o_valid     <= 1'b1;
            o_op1       <= rs_fwd;
            o_op2       <= i_alu_src ? imm_ext : rt_fwd;
            o_control   <= ctrl_d;
            o_rd_addr   <= i_rd_addr;
            o_reg_write <= i_reg_write & ~illegal_d;
            o_illegal   <= illegal_d;
            rs_addr_q   <= i_rs_addr;
            rt_addr_q   <= i_rt_addr;
            alu_src_q   <= i_alu_src;
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end else begin
            o_op1 <= op1_refresh;
            o_op2 <= op2_refresh;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a vector table for single-cycle issue plus
// hand sequences for hold/refresh, flush and reset during hold.
module tb_alu_issue_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_rs_data, i_rt_data;
    logic [4:0]  i_rs_addr, i_rt_addr, i_rd_addr;
    logic [15:0] i_imm;
    logic        i_alu_src;
    logic [1:0]  i_alu_op;
    logic [5:0]  i_funct;
    logic        i_reg_write;
    logic        i_flush;
    logic        i_exmem_we;
    logic [4:0]  i_exmem_rd;
    logic [31:0] i_exmem_data;
    logic        i_memwb_we;
    logic [4:0]  i_memwb_rd;
    logic [31:0] i_memwb_data;
    logic        i_ex_ready;
    logic        o_valid;
    logic [31:0] o_op1, o_op2;
    logic [3:0]  o_control;
    logic [4:0]  o_rd_addr;
    logic        o_reg_write;
    logic        o_illegal;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    alu_issue_stage #(.RA_W(5)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
        .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr), .i_rd_addr(i_rd_addr),
        .i_imm(i_imm), .i_alu_src(i_alu_src), .i_alu_op(i_alu_op), .i_funct(i_funct),
        .i_reg_write(i_reg_write), .i_flush(i_flush),
        .i_exmem_we(i_exmem_we), .i_exmem_rd(i_exmem_rd), .i_exmem_data(i_exmem_data),
        .i_memwb_we(i_memwb_we), .i_memwb_rd(i_memwb_rd), .i_memwb_data(i_memwb_data),
        .i_ex_ready(i_ex_ready), .o_valid(o_valid), .o_op1(o_op1), .o_op2(o_op2),
        .o_control(o_control), .o_rd_addr(o_rd_addr), .o_reg_write(o_reg_write),
        .o_illegal(o_illegal)
    );

    typedef struct {
        logic [31:0] rs_data, rt_data;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic        alu_src;
        logic [1:0]  alu_op;
        logic [5:0]  funct;
        logic        reg_write;
        logic        ex_we;  logic [4:0] ex_rd;  logic [31:0] ex_data;
        logic        wb_we;  logic [4:0] wb_rd;  logic [31:0] wb_data;
        logic [31:0] e_op1, e_op2;
        logic [3:0]  e_ctrl;
        logic        e_ill, e_rw;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid = 0; i_rs_data = '0; i_rt_data = '0; i_rs_addr = '0; i_rt_addr = '0;
        i_rd_addr = '0; i_imm = '0; i_alu_src = 0; i_alu_op = 2'b00; i_funct = '0;
        i_reg_write = 0; i_flush = 0; i_exmem_we = 0; i_exmem_rd = '0; i_exmem_data = '0;
        i_memwb_we = 0; i_memwb_rd = '0; i_memwb_data = '0;
    endtask

    task automatic drive(input vec_t v);
        i_valid = 1; i_rs_data = v.rs_data; i_rt_data = v.rt_data; i_rs_addr = v.rs;
        i_rt_addr = v.rt; i_rd_addr = v.rd; i_imm = v.imm; i_alu_src = v.alu_src;
        i_alu_op = v.alu_op; i_funct = v.funct; i_reg_write = v.reg_write;
        i_exmem_we = v.ex_we; i_exmem_rd = v.ex_rd; i_exmem_data = v.ex_data;
        i_memwb_we = v.wb_we; i_memwb_rd = v.wb_rd; i_memwb_data = v.wb_data;
    endtask

    function automatic vec_t mk(
        input logic [31:0] rs_data, input logic [31:0] rt_data,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic [15:0] imm, input logic alu_src, input logic [1:0] alu_op,
        input logic [5:0] funct, input logic reg_write,
        input logic ex_we, input logic [4:0] ex_rd, input logic [31:0] ex_data,
        input logic wb_we, input logic [4:0] wb_rd, input logic [31:0] wb_data,
        input logic [31:0] e_op1, input logic [31:0] e_op2, input logic [3:0] e_ctrl,
        input logic e_ill, input logic e_rw);
        vec_t v;
        v.rs_data = rs_data; v.rt_data = rt_data; v.rs = rs; v.rt = rt; v.rd = rd;
        v.imm = imm; v.alu_src = alu_src; v.alu_op = alu_op; v.funct = funct;
        v.reg_write = reg_write; v.ex_we = ex_we; v.ex_rd = ex_rd; v.ex_data = ex_data;
        v.wb_we = wb_we; v.wb_rd = wb_rd; v.wb_data = wb_data;
        v.e_op1 = e_op1; v.e_op2 = e_op2; v.e_ctrl = e_ctrl; v.e_ill = e_ill; v.e_rw = e_rw;
        return v;
    endfunction

    initial begin
        //            rs_data       rt_data       rs rt rd imm      src op     funct      rw  exwe exrd exdata  wbwe wbrd wbdata  e_op1         e_op2         ctrl     ill rw
        vt[0]  = mk(32'h0F0F,     32'h00FF,     3, 4, 7, 16'h0,    0, 2'b10, 6'b100100, 1,  0, 0, 0,        0, 0, 0,        32'h0F0F,     32'h00FF,     4'b0000, 0, 1);
        vt[1]  = mk(32'h1000,     32'h5,        1, 2, 8, 16'hFFFC, 1, 2'b00, 6'b0,      1,  0, 0, 0,        0, 0, 0,        32'h1000,     32'hFFFFFFFC, 4'b0010, 0, 1);
        vt[2]  = mk(32'h1000,     32'h5,        1, 2, 8, 16'hFFFC, 1, 2'b11, 6'b0,      1,  0, 0, 0,        0, 0, 0,        32'h1000,     32'h0000FFFC, 4'b0001, 0, 1);
        vt[3]  = mk(32'h99,       32'h66,       5, 6, 9, 16'h0,    0, 2'b10, 6'b100000, 1,  1, 5, 32'h11,   1, 5, 32'h22,   32'h11,       32'h66,       4'b0010, 0, 1);
        vt[4]  = mk(32'h77,       32'h88,       0, 0, 9, 16'h0,    0, 2'b10, 6'b100010, 1,  1, 0, 32'h11,   1, 0, 32'h22,   32'h77,       32'h88,       4'b0110, 0, 1);
        vt[5]  = mk(32'h1,        32'h2,        8, 9, 10, 16'h0,   0, 2'b10, 6'b101010, 1,  1, 8, 32'hAA,   1, 9, 32'h1234, 32'hAA,       32'h1234,     4'b0111, 0, 1);
        vt[6]  = mk(32'h3,        32'h4,        8, 9, 10, 16'h0,   0, 2'b10, 6'b100111, 0,  0, 8, 32'hAA,   0, 9, 32'hBB,   32'h3,        32'h4,        4'b1100, 0, 0);
        vt[7]  = mk(32'h3,        32'h4,        8, 9, 11, 16'h0,   0, 2'b10, 6'b000000, 1,  0, 0, 0,        0, 0, 0,        32'h3,        32'h4,        4'b0010, 1, 0);
        vt[8]  = mk(32'h3,        32'h4,        8, 9, 12, 16'h0,   0, 2'b10, 6'b100101, 1,  0, 0, 0,        0, 0, 0,        32'h3,        32'h4,        4'b0001, 0, 1);
        vt[9]  = mk(32'h3,        32'h4,        8, 9, 13, 16'h0,   0, 2'b10, 6'b100011, 1,  0, 0, 0,        1, 8, 32'h55,   32'h55,       32'h4,        4'b0110, 0, 1);
        vt[10] = mk(32'h3,        32'h4,        8, 9, 14, 16'h7FFF, 1, 2'b01, 6'b0,     1,  1, 9, 32'hEE,   0, 0, 0,        32'h3,        32'h00007FFF, 4'b0110, 0, 1);
        vt[11] = mk(32'h3,        32'h4,        8, 9, 15, 16'h0,   0, 2'b10, 6'b100001, 1,  0, 0, 0,        0, 0, 0,        32'h3,        32'h4,        4'b0010, 0, 1);

        idle_inputs();
        i_ex_ready = 1;
        i_rst = 1;
        step(); step();
        i_rst = 0;
        chk("rst_valid", {31'b0, o_valid}, 0);
        chk("rst_ready", {31'b0, o_ready}, 1);
        chk("rst_op1", o_op1, 0);
        chk("rst_op2", o_op2, 0);
        chk("rst_ctrl", {28'b0, o_control}, 32'h2);
        chk("rst_rd", {27'b0, o_rd_addr}, 0);
        chk("rst_rw", {31'b0, o_reg_write}, 0);
        chk("rst_ill", {31'b0, o_illegal}, 0);

        // Back-to-back issue with the ALU always consuming: no bubbles expected.
        for (int i = 0; i < 12; i++) begin
            drive(vt[i]);
            step();
            chk($sformatf("v%0d_valid", i), {31'b0, o_valid}, 1);
            chk($sformatf("v%0d_op1", i), o_op1, vt[i].e_op1);
            chk($sformatf("v%0d_op2", i), o_op2, vt[i].e_op2);
            chk($sformatf("v%0d_ctrl", i), {28'b0, o_control}, {28'b0, vt[i].e_ctrl});
            chk($sformatf("v%0d_ill", i), {31'b0, o_illegal}, {31'b0, vt[i].e_ill});
            chk($sformatf("v%0d_rw", i), {31'b0, o_reg_write}, {31'b0, vt[i].e_rw});
            chk($sformatf("v%0d_rd", i), {27'b0, o_rd_addr}, {27'b0, vt[i].rd});
        end
        idle_inputs();
        step();
        chk("drain_valid", {31'b0, o_valid}, 0);

        // Hold with register operands; MEM/WB retires rt's register mid-stall.
        drive(vt[0]);
        step();
        idle_inputs();
        i_ex_ready = 0;
        #1;
        chk("hold_ready0", {31'b0, o_ready}, 0);
        drive(vt[5]);
        i_exmem_we = 0; i_memwb_we = 0;
        step();
        chk("hold1_valid", {31'b0, o_valid}, 1);
        chk("hold1_op2", o_op2, 32'h00FF);
        chk("hold1_ctrl", {28'b0, o_control}, 32'h0);
        chk("hold1_ready", {31'b0, o_ready}, 0);
        i_memwb_we = 1; i_memwb_rd = 4; i_memwb_data = 32'hABCD;
        step();
        chk("hold2_valid", {31'b0, o_valid}, 1);
        chk("hold2_op2", o_op2, 32'hABCD);
        chk("hold2_op1", o_op1, 32'h0F0F);
        i_memwb_we = 0;
        i_exmem_we = 1; i_exmem_rd = 3; i_exmem_data = 32'h3333;
        i_memwb_we = 1; i_memwb_rd = 3; i_memwb_data = 32'h4444;
        step();
        chk("hold3_op2", o_op2, 32'hABCD);
        chk("hold3_op1", o_op1, 32'h3333);
        chk("hold3_rd", {27'b0, o_rd_addr}, 32'd7);
        chk("hold3_ready", {31'b0, o_ready}, 0);
        idle_inputs();
        i_ex_ready = 1;
        #1;
        chk("release_ready", {31'b0, o_ready}, 1);
        step();
        chk("release_valid", {31'b0, o_valid}, 0);

        // Hold with an immediate operand: rt match must not overwrite op2.
        drive(vt[1]);
        step();
        idle_inputs();
        i_ex_ready = 0;
        i_memwb_we = 1; i_memwb_rd = 2; i_memwb_data = 32'hDEAD;
        step();
        chk("imm_hold_op2", o_op2, 32'hFFFFFFFC);
        chk("imm_hold_valid", {31'b0, o_valid}, 1);

        // Flush during hold kills the held instruction.
        idle_inputs();
        i_flush = 1;
        step();
        chk("flush_hold_valid", {31'b0, o_valid}, 0);
        i_flush = 0;
        i_ex_ready = 1;

        // Flush together with an accept: nothing captured.
        drive(vt[8]);
        i_flush = 1;
        step();
        chk("flush_acc_valid", {31'b0, o_valid}, 0);
        idle_inputs();

        // Reset while holding.
        drive(vt[3]);
        step();
        idle_inputs();
        i_ex_ready = 0;
        step();
        chk("prerst_valid", {31'b0, o_valid}, 1);
        i_rst = 1;
        step();
        i_rst = 0;
        chk("midrst_valid", {31'b0, o_valid}, 0);
        chk("midrst_ready", {31'b0, o_ready}, 1);
        chk("midrst_op1", o_op1, 0);
        chk("midrst_op2", o_op2, 0);
        chk("midrst_ctrl", {28'b0, o_control}, 32'h2);
        chk("midrst_rd", {27'b0, o_rd_addr}, 0);
        chk("midrst_rw", {31'b0, o_reg_write}, 0);
        chk("midrst_ill", {31'b0, o_illegal}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
